// File: rtl/brianhg_display_read_arbiter_if.sv
// brianhg_display_read_arbiter_if: request and DDR3 read-command bundle shared by the display layers and the arbiter
interface brianhg_display_read_arbiter_if #(
   parameter int NUM_REQ          = 2,
   parameter int PORT_ADDR_SIZE   = 24,
   parameter int PORT_VECTOR_SIZE = 12,
   parameter int REQ_VEC_SIZE     = PORT_VECTOR_SIZE - $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]                req_in;
   logic [NUM_REQ*PORT_ADDR_SIZE-1:0] req_adr_in;
   logic [NUM_REQ*REQ_VEC_SIZE-1:0]   req_vec_in;
   logic [NUM_REQ-1:0]                req_busy_out;
   logic                              CMD_busy;
   logic                              CMD_ena;
   logic [PORT_ADDR_SIZE-1:0]         CMD_addr;
   logic [PORT_VECTOR_SIZE-1:0]       CMD_vector;
   logic [NUM_REQ-1:0]                ovf_err;
   modport master (
      output req_in, req_adr_in, req_vec_in, CMD_busy,
      input  req_busy_out, CMD_ena, CMD_addr, CMD_vector, ovf_err
   );
   modport slave (
      input  req_in, req_adr_in, req_vec_in, CMD_busy,
      output req_busy_out, CMD_ena, CMD_addr, CMD_vector, ovf_err
   );
endinterface

// File: rtl/brianhg_display_read_arbiter.sv
// brianhg_display_read_arbiter: round-robin burst arbiter sharing one DDR3 read port between display layers
module brianhg_display_read_arbiter #(
   parameter int NUM_REQ          = 2,
   parameter int PORT_ADDR_SIZE   = 24,
   parameter int PORT_VECTOR_SIZE = 12,
   parameter int BURST_LEN        = 8,
   parameter int FIFO_DEPTH       = 4
) (
   input logic                           CMD_CLK,
   input logic                           reset,
   brianhg_display_read_arbiter_if.slave bus
);
   localparam int ID_BITS      = $clog2(NUM_REQ);
   localparam int REQ_VEC_SIZE = PORT_VECTOR_SIZE - ID_BITS;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = PTR_W + 1;
   localparam int BC_W         = $clog2(BURST_LEN + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t                      state_q, state_d;
   logic [ID_BITS-1:0]          rr_ptr_q, rr_ptr_d, grant_q, grant_d, sel, sel_idle, scan_idx;
   logic [BC_W-1:0]             burst_cnt_q, burst_cnt_d, cnt_inc;
   logic [CNT_W-1:0]            cnt_q [NUM_REQ];
   logic [CNT_W-1:0]            cnt_d [NUM_REQ];
   logic [PTR_W-1:0]            wr_ptr_q [NUM_REQ];
   logic [PTR_W-1:0]            rd_ptr_q [NUM_REQ];
   logic [PORT_ADDR_SIZE-1:0]   adr_mem_q [NUM_REQ][FIFO_DEPTH];
   logic [REQ_VEC_SIZE-1:0]     vec_mem_q [NUM_REQ][FIFO_DEPTH];
   logic [NUM_REQ-1:0]          push, pop, busy_q, ovf_q;
   logic                        found, issue, last, drained;
   logic                        cmd_ena_q, cmd_ena_d;
   logic [PORT_ADDR_SIZE-1:0]   cmd_addr_q, cmd_addr_d;
   logic [PORT_VECTOR_SIZE-1:0] cmd_vector_q, cmd_vector_d;
   // round-robin scan, issue decision and burst bookkeeping
   always_comb begin
      found    = 1'b0;
      sel_idle = rr_ptr_q;
      scan_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = ID_BITS'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (cnt_q[scan_idx] != '0) begin
            found    = 1'b1;
            sel_idle = scan_idx;
         end
      end
      sel         = (state_q == IDLE) ? sel_idle : grant_q;
      issue       = !bus.CMD_busy && (cnt_q[sel] != '0);
      cnt_inc     = ((state_q == BURST) ? burst_cnt_q : '0) + BC_W'(issue);
      last        = issue && (cnt_inc == BC_W'(BURST_LEN));
      drained     = (state_q == BURST) && (cnt_q[grant_q] == '0) && !bus.req_in[grant_q];
      state_d     = state_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      if (state_q == IDLE && found) begin
         grant_d     = sel;
         burst_cnt_d = cnt_inc;
         state_d     = BURST;
      end else if (state_q == BURST && issue) begin
         burst_cnt_d = cnt_inc;
      end
      if (last || drained) begin
         rr_ptr_d = ID_BITS'((int'(sel) + 1) % NUM_REQ);
         state_d  = IDLE;
      end
      cmd_ena_d    = issue;
      cmd_addr_d   = issue ? adr_mem_q[sel][rd_ptr_q[sel]] : cmd_addr_q;
      cmd_vector_d = issue ? {sel, vec_mem_q[sel][rd_ptr_q[sel]]} : cmd_vector_q;
   end
   // per-requester FIFO occupancy; a full FIFO drops the incoming request
   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         push[i]  = bus.req_in[i] && (cnt_q[i] != CNT_W'(FIFO_DEPTH));
         pop[i]   = issue && (sel == ID_BITS'(i));
         cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
   end
   // control state, FIFO pointers, back-pressure, overflow flags and command registers
   always_ff @(posedge CMD_CLK) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         burst_cnt_q  <= '0;
         busy_q       <= '0;
         ovf_q        <= '0;
         cmd_ena_q    <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_vector_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i]    <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         burst_cnt_q  <= burst_cnt_d;
         cmd_ena_q    <= cmd_ena_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_vector_q <= cmd_vector_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i]    <= cnt_d[i];
            wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(pop[i]);
            busy_q[i]   <= cnt_d[i] >= CNT_W'(FIFO_DEPTH - 2);
            ovf_q[i]    <= ovf_q[i] | (bus.req_in[i] & ~push[i]);
         end
      end
   end
   // FIFO storage, written at the push edge
   always_ff @(posedge CMD_CLK) begin
      for (int i = 0; i < NUM_REQ; i++)
         if (push[i]) begin
            adr_mem_q[i][wr_ptr_q[i]] <= bus.req_adr_in[i*PORT_ADDR_SIZE +: PORT_ADDR_SIZE];
            vec_mem_q[i][wr_ptr_q[i]] <= bus.req_vec_in[i*REQ_VEC_SIZE +: REQ_VEC_SIZE];
         end
   end
   assign bus.CMD_ena      = cmd_ena_q;
   assign bus.CMD_addr     = cmd_addr_q;
   assign bus.CMD_vector   = cmd_vector_q;
   assign bus.req_busy_out = busy_q;
   assign bus.ovf_err      = ovf_q;
endmodule
